// File: rtl/x25519_field_mult.sv
// Multi-cycle a*b mod 2^255-19 multiplier: byte-serial MAC, two folds, optional freeze.
// Define X25519_MULT_FREEZE_EN to add the canonicalising FREEZE stage (latency 37 instead of 36).
//
// state    | meaning
// S_IDLE   | waiting for en; latches operands and clears ACC
// S_MAC    | ACC += A * B[8i+7:8i] << 8i, i = 0..32
// S_FOLD1  | ACC <- ACC[254:0] + 19*ACC[527:255]
// S_FOLD2  | ACC <- ACC[254:0] + 19*ACC[278:255]
// S_FREEZE | reduce to [0, p) (freeze build only)
// S_DONE   | register result, pulse out_valid
module x25519_field_mult (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         en,
   input  logic [263:0] a,
   input  logic [263:0] b,
   output logic         out_valid,
   output logic [263:0] out
);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_MAC    = 3'd1,
      S_FOLD1  = 3'd2,
      S_FOLD2  = 3'd3,
      S_FREEZE = 3'd4,
      S_DONE   = 3'd5
   } state_t;

   state_t         state_q, state_d;
   logic [263:0]   a_q, a_d;
   logic [263:0]   b_q, b_d;
   logic [527:0]   acc_q, acc_d;
   logic [5:0]     i_q, i_d;
   logic [263:0]   out_q, out_d;
   logic           out_valid_q, out_valid_d;

   logic [7:0]     b_byte;
   logic [271:0]   pp;
   logic [527:0]   mac_sum;
   logic [527:0]   fold1_sum;
   logic [527:0]   fold2_sum;

   // 19*x as shift-adds keeps the fold logic free of a generic multiplier
   function automatic logic [527:0] mul19(input logic [527:0] x);
      return (x << 4) + (x << 1) + x;
   endfunction

   assign b_byte    = b_q[{i_q, 3'b000} +: 8];
   assign pp        = {8'b0, a_q} * {264'b0, b_byte};
   assign mac_sum   = acc_q + ({256'b0, pp} << {i_q, 3'b000});
   assign fold1_sum = {273'b0, acc_q[254:0]} + mul19({255'b0, acc_q[527:255]});
   assign fold2_sum = {273'b0, acc_q[254:0]} + mul19({504'b0, acc_q[278:255]});

`ifdef X25519_MULT_FREEZE_EN
   localparam logic [255:0] P_MOD = {1'b0, {247{1'b1}}, 8'hED};
   logic [255:0] fr_sum;
   logic [255:0] fr_out;

   // R < 2^256, so one conditional +19 then one conditional -p lands in [0, p)
   assign fr_sum = {1'b0, acc_q[254:0]} + (acc_q[255] ? 256'd19 : 256'd0);
   assign fr_out = (fr_sum >= P_MOD) ? (fr_sum - P_MOD) : fr_sum;
`endif

   always_comb begin
      state_d     = state_q;
      a_d         = a_q;
      b_d         = b_q;
      acc_d       = acc_q;
      i_d         = i_q;
      out_d       = out_q;
      out_valid_d = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (en) begin
               a_d     = a;
               b_d     = b;
               acc_d   = '0;
               i_d     = '0;
               state_d = S_MAC;
            end
         end
         S_MAC: begin
            acc_d = mac_sum;
            i_d   = i_q + 6'd1;
            if (i_q == 6'd32) state_d = S_FOLD1;
         end
         S_FOLD1: begin
            acc_d   = fold1_sum;
            state_d = S_FOLD2;
         end
         S_FOLD2: begin
            acc_d   = fold2_sum;
`ifdef X25519_MULT_FREEZE_EN
            state_d = S_FREEZE;
`else
            state_d = S_DONE;
`endif
         end
`ifdef X25519_MULT_FREEZE_EN
         S_FREEZE: begin
            acc_d   = {272'b0, fr_out};
            state_d = S_DONE;
         end
`endif
         S_DONE: begin
            out_d       = {8'h00, acc_q[255:0]};
            out_valid_d = 1'b1;
            state_d     = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= S_IDLE;
         a_q         <= '0;
         b_q         <= '0;
         acc_q       <= '0;
         i_q         <= '0;
         out_q       <= '0;
         out_valid_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         a_q         <= a_d;
         b_q         <= b_d;
         acc_q       <= acc_d;
         i_q         <= i_d;
         out_q       <= out_d;
         out_valid_q <= out_valid_d;
      end
   end

   assign out       = out_q;
   assign out_valid = out_valid_q;

endmodule

// File: tb/tb_x25519_field_mult.sv
// Directed-vector bench for x25519_field_mult; expectations follow X25519_MULT_FREEZE_EN.
module tb_x25519_field_mult;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         en;
   logic [263:0] a;
   logic [263:0] b;
   logic         out_valid;
   logic [263:0] out;

   x25519_field_mult dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .en        (en),
      .a         (a),
      .b         (b),
      .out_valid (out_valid),
      .out       (out)
   );

   always #5 clk = ~clk;

`ifdef X25519_MULT_FREEZE_EN
   localparam int LAT = 37;
`else
   localparam int LAT = 36;
`endif

   int total = 0;
   int bad   = 0;
   int cyc   = 0;

   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      logic [263:0] a;
      logic [263:0] b;
      logic [263:0] exp;
      bit           mod_only;
   } vec_t;

   vec_t vecs[9];

   task automatic check(input string name, input logic [263:0] act, input logic [263:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic start_op(input logic [263:0] av, input logic [263:0] bv, output int c0);
      @(negedge clk);
      en = 1'b1;
      a  = av;
      b  = bv;
      @(posedge clk);
      #1;
      c0 = cyc;
      en = 1'b0;
   endtask

   task automatic wait_valid(output int cv, output logic [263:0] o);
      bit found;
      found = 0;
      cv    = -1;
      o     = '0;
      for (int k = 0; k < 80 && !found; k++) begin
         @(posedge clk);
         #1;
         if (out_valid) begin
            found = 1;
            cv    = cyc;
            o     = out;
         end
      end
   endtask

   logic [263:0] P;
   logic [263:0] ones;
   logic [263:0] o;
   int           c0, cv, npulse;

   initial begin
      P    = (264'd1 << 255) - 264'd19;
      ones = '1;

      vecs[0] = '{264'd2, 264'd3, 264'd6, 1'b0};
      vecs[1] = '{264'd121665, 264'd9, 264'd1094985, 1'b0};
      vecs[2] = '{264'd1 << 255, 264'd1, 264'd19, 1'b0};
`ifdef X25519_MULT_FREEZE_EN
      vecs[3] = '{P, 264'd5, 264'd0, 1'b0};
`else
      vecs[3] = '{P, 264'd5, P, 1'b0};
`endif
      // (2^264-1) = 512*2^255 - 1 == 9727 mod p, so its square is 9727^2
      vecs[4] = '{ones, ones, 264'd94614529, 1'b1};
      vecs[5] = '{264'd1 << 128, 264'd1 << 128, 264'd38, 1'b0};
      vecs[6] = '{264'd1 << 263, 264'd1 << 263, 264'd23658496, 1'b0};
      vecs[7] = '{264'd0, ones, 264'd0, 1'b0};
      vecs[8] = '{264'd12345, 264'd12345, 264'd152399025, 1'b0};

      rst_n = 1'b0;
      en    = 1'b0;
      a     = '0;
      b     = '0;
      repeat (3) @(posedge clk);
      #1;
      check("reset_valid", {263'b0, out_valid}, 264'd0);
      check("reset_out", out, 264'd0);
      @(negedge clk);
      rst_n = 1'b1;

      for (int v = 0; v < 9; v++) begin
         start_op(vecs[v].a, vecs[v].b, c0);
         wait_valid(cv, o);
         check($sformatf("latency_%0d", v), 264'(cv - c0), 264'(LAT));
`ifdef X25519_MULT_FREEZE_EN
         check($sformatf("value_%0d", v), o, vecs[v].exp);
`else
         if (vecs[v].mod_only) begin
            check($sformatf("top_byte_%0d", v), {256'b0, o[263:256]}, 264'd0);
            check($sformatf("value_mod_p_%0d", v), o % P, vecs[v].exp);
         end else begin
            check($sformatf("value_%0d", v), o, vecs[v].exp);
         end
`endif
         @(posedge clk);
         #1;
         check($sformatf("pulse_width_%0d", v), {263'b0, out_valid}, 264'd0);
         check($sformatf("out_hold_%0d", v), out, o);
      end

      // reset in the middle of MAC must drop the operation
      start_op(264'd7, 264'd11, c0);
      repeat (10) @(posedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      check("midop_reset_valid", {263'b0, out_valid}, 264'd0);
      check("midop_reset_out", out, 264'd0);
      @(negedge clk);
      rst_n  = 1'b1;
      npulse = 0;
      for (int k = 0; k < 50; k++) begin
         @(posedge clk);
         #1;
         if (out_valid) npulse++;
      end
      check("post_reset_pulses", 264'(npulse), 264'd0);

      // second request at E5 is ignored; third at the valid cycle is accepted
      start_op(264'd7, 264'd11, c0);
      repeat (4) @(posedge clk);
      #1;
      en = 1'b1;
      a  = 264'd1000;
      b  = 264'd1000;
      @(posedge clk);
      #1;
      en = 1'b0;
      a  = '0;
      b  = '0;
      wait_valid(cv, o);
      check("busy_latency", 264'(cv - c0), 264'(LAT));
      check("busy_value", o, 264'd77);
      en = 1'b1;
      a  = 264'd3;
      b  = 264'd4;
      @(posedge clk);
      #1;
      c0 = cyc;
      en = 1'b0;
      a  = '0;
      b  = '0;
      check("b2b_pulse_width", {263'b0, out_valid}, 264'd0);
      wait_valid(cv, o);
      check("b2b_latency", 264'(cv - c0), 264'(LAT));
      check("b2b_value", o, 264'd12);
      @(posedge clk);
      #1;
      check("b2b_single_pulse", {263'b0, out_valid}, 264'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
